// File: rtl/md_unit_pkg.sv
// ----------------------------------------------------------------------------
// md_unit_pkg : shared op encodings and latency defaults for the mul/div unit
// Rev 1.0     : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package md_unit_pkg;

  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  localparam int MULT_LAT_DEFAULT = 5;
  localparam int DIV_LAT_DEFAULT  = 10;

  // Any encoding that the unit acts on; NONE and the reserved code are idle.
  function automatic logic is_md_op(input logic [MD_OP_W-1:0] op);
    return (op != MD_NONE) && (op != MD_RSVD);
  endfunction

  function automatic logic is_mul_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_unit_if.sv
// ----------------------------------------------------------------------------
// md_unit_if : operand/result bundle between the controller datapath and md_unit
// Rev 1.0    : initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface md_unit_if;
  import md_unit_pkg::*;

  logic [MD_OP_W-1:0] md_op;
  logic [31:0]        src_a;
  logic [31:0]        src_b;
  logic               busy;
  logic               md_stall;
  logic [31:0]        hi;
  logic [31:0]        lo;

  modport master (
    output md_op, src_a, src_b,
    input  busy, md_stall, hi, lo
  );

  modport slave (
    input  md_op, src_a, src_b,
    output busy, md_stall, hi, lo
  );

endinterface

`default_nettype wire

// File: rtl/md_arith.sv
// ----------------------------------------------------------------------------
// md_arith : combinational 32x32 multiply / divide producing a {hi,lo} result
// Rev 1.0  : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module md_arith
  import md_unit_pkg::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  output logic [63:0]        result,
  output logic               div_by_zero
);

  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        divisor_u;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;
  logic [31:0]        mag_a;
  logic [31:0]        mag_b;
  logic [31:0]        divisor_s;
  logic [31:0]        mag_quot;
  logic [31:0]        mag_rem;
  logic [31:0]        quot_s;
  logic [31:0]        rem_s;

  always_comb begin
    a_sx   = {{32{a[31]}}, a};
    b_sx   = {{32{b[31]}}, b};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, a} * {32'd0, b};
  end

  // A zero divisor is swapped for 1 so the dividers never see X; the result
  // is discarded anyway because div_by_zero suppresses the HI/LO write.
  always_comb begin
    divisor_u = (b == 32'd0) ? 32'd1 : b;
    quot_u    = a / divisor_u;
    rem_u     = a % divisor_u;
  end

  // Signed divide on magnitudes: 0x80000000 has magnitude 0x80000000 as an
  // unsigned value, so the overflow case falls out as quotient 0x80000000.
  always_comb begin
    mag_a     = a[31] ? (~a + 32'd1) : a;
    mag_b     = b[31] ? (~b + 32'd1) : b;
    divisor_s = (mag_b == 32'd0) ? 32'd1 : mag_b;
    mag_quot  = mag_a / divisor_s;
    mag_rem   = mag_a % divisor_s;
    quot_s    = (a[31] ^ b[31]) ? (~mag_quot + 32'd1) : mag_quot;
    rem_s     = a[31] ? (~mag_rem + 32'd1) : mag_rem;
  end

  always_comb begin
    div_by_zero = is_div_op(op) && (b == 32'd0);
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = {rem_s, quot_s};
      MD_DIVU:  result = {rem_u, quot_u};
      default:  result = 64'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/md_unit.sv
// ----------------------------------------------------------------------------
// md_unit : multi-cycle multiply/divide unit owning the architectural HI/LO
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEFAULT,
  parameter int DIV_LAT  = DIV_LAT_DEFAULT
)(
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  bus
);

  localparam int MULT_LAT_C = (MULT_LAT < 1) ? 1 : MULT_LAT;
  localparam int DIV_LAT_C  = (DIV_LAT  < 1) ? 1 : DIV_LAT;
  localparam int MAX_LAT    = (MULT_LAT_C > DIV_LAT_C) ? MULT_LAT_C : DIV_LAT_C;
  localparam int CNT_W      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] MULT_CNT_INIT = CNT_W'(MULT_LAT_C - 1);
  localparam logic [CNT_W-1:0] DIV_CNT_INIT  = CNT_W'(DIV_LAT_C - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic             pend_wr_q, pend_wr_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [63:0]      arith_result;
  logic             arith_dbz;
  logic             busy;
  logic             accept_mul;
  logic             accept_div;

  md_arith u_arith (
    .op          (bus.md_op),
    .a           (bus.src_a),
    .b           (bus.src_b),
    .result      (arith_result),
    .div_by_zero (arith_dbz)
  );

  always_comb begin
    busy       = (state_q == ST_BUSY);
    accept_mul = !busy && is_mul_op(bus.md_op);
    accept_div = !busy && is_div_op(bus.md_op);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_mul || accept_div) begin
          pend_d    = arith_result;
          pend_wr_d = !arith_dbz;
          cnt_d     = accept_mul ? MULT_CNT_INIT : DIV_CNT_INIT;
          state_d   = ST_BUSY;
        end else if (bus.md_op == MD_MTHI) begin
          hi_d = bus.src_a;
        end else if (bus.md_op == MD_MTLO) begin
          lo_d = bus.src_a;
        end
      end
      default: begin
        // Everything on md_op is ignored here; the controller keeps stalling.
        if (cnt_q == '0) begin
          if (pend_wr_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
          pend_wr_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy     = busy;
  assign bus.md_stall = busy | is_md_op(bus.md_op);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

`default_nettype wire
